// File: rtl/cpu_pkg.sv
// Shared opcode, width and state definitions for the 4-bit accumulator CPU sequencer.
package cpu_pkg;

  localparam int PC_W_DEF    = 3;
  localparam int INSTR_W_DEF = 4;

  // ir[3] set selects JMP; otherwise ir[2:0] holds one of these opcodes
  localparam int JMP_BIT = 3;

  localparam logic [2:0] OP_NOP  = 3'b000;
  localparam logic [2:0] OP_LD   = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
  localparam logic [2:0] OP_SKC  = 3'b100;
  localparam logic [2:0] OP_HALT = 3'b101;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    EXEC,
    HALTED,
    WAIT_STEP
  } seq_state_e;

endpackage

// File: rtl/cpu_sequencer_if.sv
// Sequencer <-> datapath/host bus. CPU_SEQ_SINGLE_STEP_EN adds step/waiting.
interface cpu_sequencer_if
  import cpu_pkg::*;
#(
  parameter int PC_W    = PC_W_DEF,
  parameter int INSTR_W = INSTR_W_DEF
);
  logic               start;
  logic [INSTR_W-1:0] rom_data;
  logic               alu_carry;
  logic [PC_W-1:0]    rom_addr;
  logic [PC_W-1:0]    pc_out;
  logic               mux_sel;
  logic               reg_load;
  logic               alu_sub;
  logic               carry_flag;
  logic               busy;
  logic               halted;
`ifdef CPU_SEQ_SINGLE_STEP_EN
  logic               step;
  logic               waiting;

  modport master (
    input  start, rom_data, alu_carry, step,
    output rom_addr, pc_out, mux_sel, reg_load, alu_sub, carry_flag, busy, halted, waiting
  );
  modport slave (
    output start, rom_data, alu_carry, step,
    input  rom_addr, pc_out, mux_sel, reg_load, alu_sub, carry_flag, busy, halted, waiting
  );
`else
  modport master (
    input  start, rom_data, alu_carry,
    output rom_addr, pc_out, mux_sel, reg_load, alu_sub, carry_flag, busy, halted
  );
  modport slave (
    output start, rom_data, alu_carry,
    input  rom_addr, pc_out, mux_sel, reg_load, alu_sub, carry_flag, busy, halted
  );
`endif
endinterface

// File: rtl/cpu_decode.sv
// Combinational instruction decode; every output is forced low unless exec_en.
module cpu_decode
  import cpu_pkg::*;
#(
  parameter int INSTR_W = INSTR_W_DEF
) (
  input  logic [INSTR_W-1:0] ir,
  input  logic               exec_en,
  output logic               mux_sel,
  output logic               reg_load,
  output logic               alu_sub,
  output logic               is_jmp,
  output logic               is_skc,
  output logic               is_halt,
  output logic               updates_carry
);

  always_comb begin
    mux_sel       = 1'b0;
    reg_load      = 1'b0;
    alu_sub       = 1'b0;
    is_jmp        = 1'b0;
    is_skc        = 1'b0;
    is_halt       = 1'b0;
    updates_carry = 1'b0;
    if (exec_en) begin
      if (ir[JMP_BIT]) begin
        is_jmp = 1'b1;
      end else begin
        case (ir[2:0])
          OP_LD: reg_load = 1'b1;
          OP_ADD, OP_SUB: begin
            mux_sel       = 1'b1;
            reg_load      = 1'b1;
            alu_sub       = ir[0];
            updates_carry = 1'b1;
          end
          OP_SKC:  is_skc  = 1'b1;
          OP_HALT: is_halt = 1'b1;
          default: ;  // NOP and reserved opcodes
        endcase
      end
    end
  end

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle fetch/execute controller owning PC, IR and carry flag.
// Optional macro CPU_SEQ_SINGLE_STEP_EN parks in WAIT_STEP after each instruction.
module cpu_sequencer
  import cpu_pkg::*;
#(
  parameter int PC_W    = PC_W_DEF,
  parameter int INSTR_W = INSTR_W_DEF,
  parameter int ROM_LAT = 1
) (
  input  logic            clk,
  input  logic            rstn,
  cpu_sequencer_if.master bus
);

  localparam logic [1:0] FCNT_LAST = 2'(ROM_LAT - 1);

  seq_state_e         state;
  seq_state_e         next_state;
  logic [PC_W-1:0]    pc;
  logic [PC_W-1:0]    pc_next;
  logic [INSTR_W-1:0] ir;
  logic               carry;
  logic [1:0]         fcnt;

  logic exec_en;
  logic fetch_last;
  logic launch;
  logic mux_sel, reg_load, alu_sub, is_jmp, is_skc, is_halt, updates_carry;

  assign fetch_last = (state == FETCH) && (fcnt == FCNT_LAST);
  assign launch     = bus.start && ((state == IDLE) || (state == HALTED));

  cpu_decode #(.INSTR_W(INSTR_W)) u_decode (
    .ir            (ir),
    .exec_en       (exec_en),
    .mux_sel       (mux_sel),
    .reg_load      (reg_load),
    .alu_sub       (alu_sub),
    .is_jmp        (is_jmp),
    .is_skc        (is_skc),
    .is_halt       (is_halt),
    .updates_carry (updates_carry)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:   if (bus.start) next_state = FETCH;
      FETCH:  if (fetch_last) next_state = EXEC;
`ifdef CPU_SEQ_SINGLE_STEP_EN
      EXEC:      next_state = is_halt ? HALTED : WAIT_STEP;
      WAIT_STEP: if (bus.step) next_state = FETCH;
`else
      EXEC:      next_state = is_halt ? HALTED : FETCH;
      WAIT_STEP: next_state = IDLE;
`endif
      HALTED: if (bus.start) next_state = FETCH;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    exec_en    = (state == EXEC);
    bus.busy   = (state == FETCH) || (state == EXEC);
    bus.halted = (state == HALTED);
`ifdef CPU_SEQ_SINGLE_STEP_EN
    bus.waiting = (state == WAIT_STEP);
`endif
  end

  // HALT leaves pc in place so halted programs report their stop address
  always_comb begin
    if (is_jmp)             pc_next = PC_W'(ir[2:0]);
    else if (is_halt)       pc_next = pc;
    else if (is_skc && carry) pc_next = pc + PC_W'(2);
    else                    pc_next = pc + PC_W'(1);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pc    <= '0;
      ir    <= '0;
      carry <= 1'b0;
      fcnt  <= '0;
    end else begin
      if (launch) begin
        pc    <= '0;
        carry <= 1'b0;
      end
      if (state == FETCH) begin
        if (fetch_last) begin
          ir   <= bus.rom_data;
          fcnt <= '0;
        end else begin
          fcnt <= fcnt + 2'd1;
        end
      end
      if (exec_en) begin
        pc <= pc_next;
        if (updates_carry) carry <= bus.alu_carry;
      end
    end
  end

  assign bus.rom_addr   = pc;
  assign bus.pc_out     = pc;
  assign bus.carry_flag = carry;
  assign bus.mux_sel    = mux_sel;
  assign bus.reg_load   = reg_load;
  assign bus.alu_sub    = alu_sub;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed bench: accumulator datapath around a ROM_LAT=1 sequencer, plus a ROM_LAT=3 instance.
module tb_cpu_sequencer;
  import cpu_pkg::*;

  logic clk = 1'b0;
  logic rstn;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  cpu_sequencer_if #(.PC_W(3), .INSTR_W(4)) bus ();
  cpu_sequencer_if #(.PC_W(3), .INSTR_W(4)) bus3 ();

  cpu_sequencer #(.PC_W(3), .INSTR_W(4), .ROM_LAT(1)) u_dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  cpu_sequencer #(.PC_W(3), .INSTR_W(4), .ROM_LAT(3)) u_dut3 (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus3)
  );

  logic [3:0] rom  [8];
  logic [3:0] rom3 [8];
  logic [3:0] ext_in;
  logic [3:0] acc;
  logic [4:0] alu_full;
  localparam logic [3:0] ALU_B = 4'b0001;

  assign bus.rom_data  = rom[bus.rom_addr];
  assign alu_full      = bus.alu_sub ? ({1'b0, acc} - {1'b0, ALU_B}) : ({1'b0, acc} + {1'b0, ALU_B});
  assign bus.alu_carry = alu_full[4];
  assign bus3.rom_data  = rom3[bus3.rom_addr];
  assign bus3.alu_carry = 1'b0;
`ifdef CPU_SEQ_SINGLE_STEP_EN
  logic step3;
  assign bus.step  = 1'b0;
  assign bus3.step = step3;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)             acc <= '0;
    else if (bus.reg_load) acc <= bus.mux_sel ? alu_full[3:0] : ext_in;
  end

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic launch();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  initial begin
    rstn       = 1'b0;
    bus.start  = 1'b1;
    bus3.start = 1'b0;
`ifdef CPU_SEQ_SINGLE_STEP_EN
    step3 = 1'b0;
`endif
    ext_in = 4'd3;
    rom = '{4'h1, 4'h2, 4'h2, 4'h5, 4'h0, 4'h0, 4'h0, 4'h0};
    rom3 = '{4'h0, 4'h0, 4'h5, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};

    // 1: reset with start held, then LD/ADD/ADD/HALT
    for (int c = 0; c < 3; c++) begin
      tick();
      check("rst_outs", {7'd0, bus.busy, bus.halted, bus.reg_load, bus.mux_sel,
                         bus.alu_sub, bus.carry_flag, bus.pc_out}, 16'd0);
    end
    rstn = 1'b1;
    tick();
    check("c1_busy", {15'd0, bus.busy}, 16'd1);
    check("c1_addr", {13'd0, bus.rom_addr}, 16'd0);
    bus.start = 1'b0;
    for (int c = 2; c <= 7; c++) begin
      tick();
      check($sformatf("c%0d_load", c), {15'd0, bus.reg_load}, (c == 2 || c == 4 || c == 6) ? 16'd1 : 16'd0);
    end
    tick(2);
    check("t1_halted", {15'd0, bus.halted}, 16'd1);
    check("t1_pc", {13'd0, bus.pc_out}, 16'd3);
    check("t1_acc", {12'd0, acc}, 16'd5);

    // 2: carry and skip
    rom = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h5, 4'h0, 4'h0, 4'h0};
    ext_in = 4'hF;
    launch();
    check("t2_pc0", {13'd0, bus.pc_out}, 16'd0);
    tick(4);
    check("t2_carry", {15'd0, bus.carry_flag}, 16'd1);
    check("t2_pc2", {13'd0, bus.pc_out}, 16'd2);
    tick(2);
    check("t2_skip", {13'd0, bus.pc_out}, 16'd4);
    tick(2);
    check("t2_halted", {15'd0, bus.halted}, 16'd1);
    check("t2_pc4", {13'd0, bus.pc_out}, 16'd4);
    check("t2_carry_hold", {15'd0, bus.carry_flag}, 16'd1);

    // 3: no-skip path; also restart after HALT clears carry
    ext_in = 4'h5;
    launch();
    check("t3_restart_carry", {15'd0, bus.carry_flag}, 16'd0);
    check("t3_a0", {13'd0, bus.rom_addr}, 16'd0);
    tick(2);
    check("t3_a1", {13'd0, bus.rom_addr}, 16'd1);
    tick(2);
    check("t3_a2", {13'd0, bus.rom_addr}, 16'd2);
    check("t3_carry", {15'd0, bus.carry_flag}, 16'd0);
    tick(2);
    check("t3_a3", {13'd0, bus.rom_addr}, 16'd3);
    tick(2);
    check("t3_a0b", {13'd0, bus.rom_addr}, 16'd0);

    // 5: start ignored while busy, then reset during EXEC of a carrying ADD
    bus.start = 1'b1;
    ext_in = 4'hF;
    tick();
    check("t5_busy", {15'd0, bus.busy}, 16'd1);
    tick();
    check("t5_start_ign", {13'd0, bus.pc_out}, 16'd1);
    bus.start = 1'b0;
    tick();
    check("t5_add_load", {14'd0, bus.reg_load, bus.mux_sel}, 16'd3);
    rstn = 1'b0;
    #1;
    check("t5_rst_load", {15'd0, bus.reg_load}, 16'd0);
    check("t5_rst_carry", {15'd0, bus.carry_flag}, 16'd0);
    check("t5_rst_busy", {15'd0, bus.busy}, 16'd0);
    tick();
    rstn = 1'b1;
    tick();
    check("t5_idle", {12'd0, bus.busy, bus.pc_out}, 16'd0);

    // 4: NOP wrap-around
    rom = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
    launch();
    for (int k = 1; k <= 8; k++) begin
      tick(2);
      check($sformatf("t4_pc%0d", k), {13'd0, bus.pc_out}, 16'(k % 8));
    end
    check("t4_no_halt", {15'd0, bus.halted}, 16'd0);

    // 4b: SKC at address 7 with carry set wraps to 1
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    rom = '{4'h1, 4'h2, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 4'h4};
    ext_in = 4'hF;
    launch();
    tick(6);
    check("t4_pc7", {13'd0, bus.pc_out}, 16'd7);
    check("t4_carry7", {15'd0, bus.carry_flag}, 16'd1);
    tick(2);
    check("t4_skc_wrap", {13'd0, bus.pc_out}, 16'd1);

    // 6: ROM_LAT=3 instance
    bus3.start = 1'b1;
    tick();
    bus3.start = 1'b0;
    check("t6_fetch0", {12'd0, bus3.busy, bus3.pc_out}, 16'h8);
    tick(3);
    check("t6_exec0", {12'd0, bus3.busy, bus3.pc_out}, 16'h8);
    tick();
`ifdef CPU_SEQ_SINGLE_STEP_EN
    check("t6_wait", {11'd0, bus3.waiting, bus3.busy, bus3.pc_out}, 16'h11);
    bus3.start = 1'b1;
    tick(2);
    check("t6_wait_start", {11'd0, bus3.waiting, bus3.busy, bus3.pc_out}, 16'h11);
    bus3.start = 1'b0;
    step3 = 1'b1;
    tick();
    step3 = 1'b0;
    check("t6_step", {11'd0, bus3.waiting, bus3.busy, bus3.pc_out}, 16'h09);
    tick(4);
    check("t6_wait2", {11'd0, bus3.waiting, bus3.pc_out}, 16'h12);
    step3 = 1'b1;
    tick();
    step3 = 1'b0;
    tick(3);
    check("t6_exec_halt", {14'd0, bus3.halted, bus3.busy}, 16'd1);
    tick();
    check("t6_halted", {14'd0, bus3.halted, bus3.waiting}, 16'd2);
`else
    check("t6_fetch1", {12'd0, bus3.busy, bus3.pc_out}, 16'h9);
    tick(4);
    check("t6_fetch2", {13'd0, bus3.pc_out}, 16'd2);
    tick(3);
    check("t6_exec_halt", {14'd0, bus3.halted, bus3.busy}, 16'd1);
    tick();
    check("t6_halted", {14'd0, bus3.halted, bus3.busy}, 16'd2);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
